// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: frames the stream, packs RGB565 and writes a linear frame buffer.
// Optional 2:1 downscale in each axis when CAPTURE_DECIMATE_EN is defined.
module ov7670_capture #(
    parameter int unsigned H_PIX   = 320,
    parameter int unsigned V_LINES = 240,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              line_err
);

`ifdef CAPTURE_DECIMATE_EN
    localparam int unsigned DEC = 2;
`else
    localparam int unsigned DEC = 1;
`endif
    localparam int unsigned IN_H = H_PIX * DEC;
    localparam int unsigned IN_V = V_LINES * DEC;
    localparam int unsigned PW   = $clog2(IN_H + 1);
    localparam int unsigned LW   = $clog2(IN_V + 1);
    localparam logic [PW-1:0]     PX_MAX = PW'(IN_H);
    localparam logic [LW-1:0]     LN_MAX = LW'(IN_V);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(H_PIX * V_LINES - 1);

    typedef enum logic [1:0] {StSync, StWait, StActive} state_t;

    state_t state_q, state_d;

    logic          vs_r, vs_r2, href_r, href_r2;
    logic [7:0]    d_r, hi_q;
    logic          phase_q, full_q;
    logic [PW-1:0] px_q;
    logic [LW-1:0] line_q;

    logic vs_rise, vs_fall, href_fall, pix_fire, keep, cap, wr, err, done_all;
    logic start, frame_end;

    assign vs_rise   = vs_r & ~vs_r2;
    assign vs_fall   = ~vs_r & vs_r2;
    assign href_fall = href_r2 & ~href_r;
    assign pix_fire  = href_r & phase_q;
    assign done_all  = full_q | (we & (addr == LAST));

`ifdef CAPTURE_DECIMATE_EN
    assign keep = ~px_q[0] & ~line_q[0];
`else
    assign keep = 1'b1;
`endif

    // A pixel finishing on the vsync rising edge belongs to a truncated frame and is dropped.
    assign cap = (state_q == StActive) & ~vs_rise & pix_fire;
    assign wr  = cap & keep & ~full_q & (px_q < PX_MAX) & (line_q < LN_MAX);
    assign err = cap & ((px_q >= PX_MAX) | (line_q >= LN_MAX) | (keep & full_q));

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            StSync: begin
                if (vs_r) state_d = StWait;
            end
            StWait: begin
                if (vs_fall && capture_en) begin
                    start   = 1'b1;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_d   = StWait;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state_q <= StSync;
        else        state_q <= state_d;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r       <= 1'b0;
            vs_r2      <= 1'b0;
            href_r     <= 1'b0;
            href_r2    <= 1'b0;
            d_r        <= '0;
            hi_q       <= '0;
            phase_q    <= 1'b0;
            px_q       <= '0;
            line_q     <= '0;
            full_q     <= 1'b0;
            addr       <= '0;
            dout       <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            vs_r    <= vsync;
            vs_r2   <= vs_r;
            href_r  <= href;
            href_r2 <= href_r;
            d_r     <= d;
            phase_q <= href_r & ~phase_q;
            if (href_r && !phase_q) hi_q <= d_r;

            if (!href_r)                      px_q <= '0;
            else if (pix_fire && px_q != PX_MAX) px_q <= px_q + PW'(1);

            if (start) line_q <= '0;
            else if (state_q == StActive && href_fall && line_q != LN_MAX)
                line_q <= line_q + LW'(1);

            we <= wr;
            if (wr) dout <= {hi_q, d_r};

            // addr holds the current write address and advances once the write is out.
            if (start)                      addr <= '0;
            else if (we && addr != LAST)    addr <= addr + ADDR_W'(1);

            if (start)                      full_q <= 1'b0;
            else if (we && addr == LAST)    full_q <= 1'b1;

            if (start)    line_err <= 1'b0;
            else if (err) line_err <= 1'b1;

            frame_done <= frame_end;
            if (frame_end) frame_ok <= done_all & ~line_err;
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 16x8 buffer; ramp frames, byte order,
// malformed lines, short/over-count frames, enable gating and mid-frame reset.
module tb_ov7670_capture;

    localparam int unsigned H  = 16;
    localparam int unsigned V  = 8;
    localparam int unsigned AW = 7;
`ifdef CAPTURE_DECIMATE_EN
    localparam int DEC = 2;
`else
    localparam int DEC = 1;
`endif
    localparam int IN_H = H * DEC;
    localparam int IN_V = V * DEC;
    localparam int NPIX = H * V;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          capture_en = 1'b1;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    d = 8'h00;
    logic [AW-1:0] addr;
    logic [15:0]   dout;
    logic          we, frame_done, frame_ok, line_err;

    always #5 pclk = ~pclk;

    ov7670_capture #(
        .H_PIX  (H),
        .V_LINES(V),
        .ADDR_W (AW)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .capture_en(capture_en),
        .vsync     (vsync),
        .href      (href),
        .d         (d),
        .addr      (addr),
        .dout      (dout),
        .we        (we),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .line_err  (line_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [15:0]   wd_q[$];
    int            fd_cnt = 0;
    int            b2b = 0;
    logic          prev_we = 1'b0;

    always @(posedge pclk) begin
        #2;
        if (we) begin
            wa_q.push_back(addr);
            wd_q.push_back(dout);
            if (prev_we) b2b = b2b + 1;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        prev_we <= we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int a);
        int k;
        k = (a / H) * DEC * IN_H + (a % H) * DEC;
        return k[15:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic clear_rec();
        wa_q.delete();
        wd_q.delete();
        fd_cnt = 0;
    endtask

    task automatic send_line(input int li, input int nb);
        logic [15:0] k;
        for (int b = 0; b < nb; b++) begin
            @(negedge pclk);
            k    = 16'(li * IN_H + b / 2);
            href = 1'b1;
            d    = (b % 2 == 0) ? k[15:8] : k[7:0];
        end
        @(negedge pclk);
        href = 1'b0;
        d    = 8'h00;
        idle(3);
    endtask

    task automatic send_frame(input int nl, input int long_li, input int odd_li);
        for (int li = 0; li < nl; li++)
            send_line(li, 2 * IN_H + ((li == long_li) ? 2 : 0) + ((li == odd_li) ? 1 : 0));
    endtask

    // Raise vsync (ending any frame), then drop it (starting the next one if enabled).
    task automatic vblank(input bit chk, input bit exp_done);
        @(negedge pclk);
        vsync = 1'b1;
        href  = 1'b0;
        if (chk) begin
            @(posedge pclk); #2;
            check("fd_early", frame_done, 0);
            @(posedge pclk); #2;
            check("fd_timing", frame_done, exp_done);
        end
        idle(4);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic verify_frame(input int n);
        check("wr_cnt", wa_q.size(), n);
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            check("wr_addr", wa_q[i], i);
            check("wr_data", wd_q[i], exp_pix(i));
        end
    endtask

    logic [31:0] last_a;

    initial begin
        idle(3);
        check("rst_addr", addr, 0);
        check("rst_dout", dout, 0);
        check("rst_we", we, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ok", frame_ok, 0);
        check("rst_err", line_err, 0);

        // Reset in the middle of a line of a frame that is being captured.
        @(negedge pclk) rst_n = 1'b1;
        vblank(0, 0);
        for (int b = 0; b < 24; b++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = 8'(b + 1);
            if (b == 14) rst_n = 1'b0;
            if (b == 15) check("midrst_addr", addr, 0);
            if (b == 16) begin
                rst_n = 1'b1;
                clear_rec();
            end
        end
        @(negedge pclk) href = 1'b0;
        idle(3);
        send_line(1, 2 * IN_H);
        send_line(2, 2 * IN_H);
        check("midrst_nowr", wa_q.size(), 0);
        vblank(0, 0);

        // Full ramp frame.
        clear_rec();
        send_frame(IN_V, -1, -1);
        vblank(1, 1);
        verify_frame(NPIX);
        check("full_ok", frame_ok, 1);
        check("full_err", line_err, 0);
        check("full_fdcnt", fd_cnt, 1);

        // Byte order and write latency on a single-pixel frame.
        clear_rec();
        @(negedge pclk);
        href = 1'b1;
        d    = 8'hF8;
        @(negedge pclk) d = 8'h1F;
        @(posedge pclk); #2;
        check("lat_early", we, 0);
        @(negedge pclk);
        href = 1'b0;
        d    = 8'h00;
        @(posedge pclk); #2;
        check("lat_we", we, 1);
        check("lat_dout", dout, 16'hF81F);
        check("lat_addr", addr, 0);
        idle(3);
        vblank(1, 1);
        check("one_cnt", wa_q.size(), 1);
        check("one_ok", frame_ok, 0);

        // Over-length line 2 and odd-length line 4.
        clear_rec();
        send_frame(IN_V, 2, 4);
        check("long_err", line_err, 1);
        vblank(1, 1);
        check("long_ok", frame_ok, 0);
        verify_frame(NPIX);
        check("err_clr", line_err, 0);

        // Short frame: one stored line missing.
        clear_rec();
        send_frame(IN_V - DEC, -1, -1);
        check("short_err", line_err, 0);
        vblank(1, 1);
        verify_frame((V - 1) * H);
        last_a = (wa_q.size() > 0) ? 32'(wa_q[wa_q.size() - 1]) : 32'hFFFF_FFFF;
        check("short_last", last_a, (V - 1) * H - 1);
        check("short_ok", frame_ok, 0);

        // Over-count frame: addr saturates at the last location.
        clear_rec();
        send_frame(IN_V + 1, -1, -1);
        check("ovc_err", line_err, 1);
        check("ovc_addr", addr, NPIX - 1);
        vblank(1, 1);
        check("ovc_ok", frame_ok, 0);
        verify_frame(NPIX);

        // Enable dropped mid-frame: this frame completes, the next is skipped.
        clear_rec();
        for (int li = 0; li < IN_V; li++) begin
            if (li == IN_V / 2) capture_en = 1'b0;
            send_line(li, 2 * IN_H);
        end
        vblank(1, 1);
        check("gate_ok", frame_ok, 1);
        verify_frame(NPIX);
        clear_rec();
        send_frame(IN_V, -1, -1);
        capture_en = 1'b1;
        vblank(1, 0);
        check("gate_nowr", wa_q.size(), 0);
        check("gate_nofd", fd_cnt, 0);
        clear_rec();
        send_frame(IN_V, -1, -1);
        vblank(1, 1);
        verify_frame(NPIX);
        check("reen_ok", frame_ok, 1);

        check("no_b2b", b2b, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
